// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide engine (MULT, MULTU, DIV, DIVU) producing a
// 2*WIDTH-bit hi/lo result and a single-cycle HI/LO write strobe.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Operand capture: signed ops work on magnitudes, sign restored in FIX.
  logic             cap_a_neg, cap_b_neg;
  logic [WIDTH-1:0] cap_a_mag, cap_b_mag;

  assign cap_a_neg = ~op[0] & a[WIDTH-1];
  assign cap_b_neg = ~op[0] & b[WIDTH-1];
  assign cap_a_mag = cap_a_neg ? -a : a;
  assign cap_b_mag = cap_b_neg ? -b : b;

  // Multiply step: add multiplicand into the upper half, shift right with carry.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Divide step: shift left, subtract divisor when it fits, shift in quotient bit.
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_rem_new;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next    = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge      = div_rem_sh >= {1'b0, opnd_q};
  assign div_rem_new = div_ge ? (div_rem_sh - {1'b0, opnd_q}) : div_rem_sh;
  assign div_next    = {div_rem_new[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    a_raw_d   = a_raw_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // A request is taken in IDLE, or in DONE so back-to-back ops lose no edge.
    if (start && !cancel && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_d   = S_CALC;
      cnt_d     = '0;
      is_div_d  = op[1];
      neg_d     = cap_a_neg ^ cap_b_neg;
      neg_rem_d = cap_a_neg;
      dz_d      = (b == '0);
      a_raw_d   = a;
      opnd_d    = cap_b_mag;
      acc_d     = {{WIDTH{1'b0}}, cap_a_mag};
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CALC: begin
          if (cancel) begin
            state_d = S_IDLE;
          end else begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
          end
        end
        S_FIX: begin
          if (cancel) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!is_div_q) begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end else if (dz_q) begin
              hi_d = a_raw_q;
              lo_d = {WIDTH{1'b1}};
            end else begin
              hi_d = rem_fix;
              lo_d = quot_fix;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      a_raw_q   <= a_raw_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // A flush during DONE suppresses the write as well as the return path.
  assign busy    = (state_q != S_IDLE);
  assign hilo_we = (state_q == S_DONE) && !cancel;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, random ops against an
// arithmetic reference model, start-while-busy, back-to-back, cancel and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy, hilo_we;
  logic [31:0] hi_o, lo_o;

  int vectors = 0;
  int errors  = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busy), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // Reference: {hi, lo} straight from the arithmetic definitions.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy, uq, ur;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return ux * uy;
      OP_DIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Issue one op; negedge n counts from the start-sampling edge E0.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l,
                        output int first_we, output int we_cnt, output logic busy_after);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    first_we = -1; we_cnt = 0; h = 'x; l = 'x; busy_after = 1'bx;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (hilo_we) begin
        we_cnt++;
        if (first_we < 0) first_we = n;
        h = hi_o; l = lo_o;
      end
      if (n == 35) busy_after = busy;
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, hilo_we, hi_o, lo_o} !== 66'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b we=%b hi=%h lo=%h, required all zero", busy, hilo_we, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] h, l;
    int fw, wc;
    logic ba;
    logic [63:0] exp;
    exp = model(o, x, y);
    run_op(o, x, y, h, l, fw, wc, ba);
    vectors++;
    if ({h, l} !== exp) begin
      errors++;
      $display("FAIL %s result op=%0d a=%h b=%h: got hi=%h lo=%h, required hi=%h lo=%h",
               name, o, x, y, h, l, exp[63:32], exp[31:0]);
    end
    vectors++;
    if (fw !== 34 || wc !== 1) begin
      errors++;
      $display("FAIL %s strobe: first at n=%0d count=%0d, required n=34 count=1", name, fw, wc);
    end
    vectors++;
    if (ba !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_E34: got %b, required 0", name, ba);
    end
  endtask

  task automatic test_directed();
    check_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd5);
    check_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000);
    check_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2);
    check_op("divu_small", OP_DIVU,  32'd100, 32'd7);
    check_op("divu_zero",  OP_DIVU,  32'd100, 32'd0);
    check_op("div_zero",   OP_DIV,   32'hFFFF_FF9C, 32'd0);
    check_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    check_op("div_remneg", OP_DIV,   32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 15));
        1: y = -32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      check_op("random", o, x, y);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] exp;
    int fw;
    logic [31:0] h, l;
    exp = model(OP_MULTU, 32'h1234_5678, 32'h0000_9ABC);
    @(negedge clk);
    op = OP_MULTU; a = 32'h1234_5678; b = 32'h0000_9ABC; start = 1'b1;
    @(posedge clk);
    fw = -1; h = 'x; l = 'x;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 9) begin op = OP_DIV; a = 32'hDEAD_BEEF; b = 32'h3; start = 1'b1; end
      if (n == 10) start = 1'b0;
      if (hilo_we && fw < 0) begin fw = n; h = hi_o; l = lo_o; end
    end
    vectors++;
    if ({h, l} !== exp || fw !== 34) begin
      errors++;
      $display("FAIL start_ignored: got hi=%h lo=%h at n=%0d, required hi=%h lo=%h at n=34",
               h, l, fw, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp1, exp2;
    logic [31:0] h1, l1, h2, l2;
    int w1, w2, wc;
    logic b35;
    exp1 = model(OP_MULT, 32'hFFFF_0001, 32'h0000_7FFF);
    exp2 = model(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
    @(negedge clk);
    op = OP_MULT; a = 32'hFFFF_0001; b = 32'h0000_7FFF; start = 1'b1;
    @(posedge clk);
    w1 = -1; w2 = -1; wc = 0; b35 = 1'bx;
    h1 = 'x; l1 = 'x; h2 = 'x; l2 = 'x;
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (hilo_we) begin
        wc++;
        if (w1 < 0) begin w1 = n; h1 = hi_o; l1 = lo_o; end
        else if (w2 < 0) begin w2 = n; h2 = hi_o; l2 = lo_o; end
      end
      if (n == 34) begin op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'h0000_0010; start = 1'b1; end
      if (n == 35) begin start = 1'b0; b35 = busy; end
    end
    vectors++;
    if ({h1, l1} !== exp1 || w1 !== 34) begin
      errors++;
      $display("FAIL b2b_first: got hi=%h lo=%h at n=%0d, required hi=%h lo=%h at n=34", h1, l1, w1, exp1[63:32], exp1[31:0]);
    end
    vectors++;
    if ({h2, l2} !== exp2 || w2 !== 68 || wc !== 2) begin
      errors++;
      $display("FAIL b2b_second: got hi=%h lo=%h at n=%0d strobes=%0d, required hi=%h lo=%h at n=68 strobes=2",
               h2, l2, w2, wc, exp2[63:32], exp2[31:0]);
    end
    vectors++;
    if (b35 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b after E34, required 1 (second op running)", b35);
    end
  endtask

  task automatic test_cancel();
    logic [63:0] prev;
    logic [31:0] h, l;
    int fw, wc;
    logic ba, b16;
    prev = model(OP_MULTU, 32'h0BAD_F00D, 32'h0000_0123);
    run_op(OP_MULTU, 32'h0BAD_F00D, 32'h0000_0123, h, l, fw, wc, ba);
    @(negedge clk);
    op = OP_DIVU; a = 32'd999; b = 32'd10; start = 1'b1;
    @(posedge clk);
    wc = 0; b16 = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (hilo_we) wc++;
      if (n == 15) cancel = 1'b1;
      if (n == 16) begin cancel = 1'b0; b16 = busy; end
    end
    vectors++;
    if (b16 !== 1'b0 || wc !== 0) begin
      errors++;
      $display("FAIL cancel_calc: busy after E16=%b strobes=%0d, required busy=0 strobes=0", b16, wc);
    end
    vectors++;
    if ({hi_o, lo_o} !== prev) begin
      errors++;
      $display("FAIL cancel_hold: got hi=%h lo=%h, required hi=%h lo=%h", hi_o, lo_o, prev[63:32], prev[31:0]);
    end
    @(negedge clk);
    op = OP_MULT; a = 32'd3; b = 32'd4; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cancel_wins: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    int wc;
    @(negedge clk);
    op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'h7; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, hilo_we, hi_o, lo_o} !== 66'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b we=%b hi=%h lo=%h, required all zero", busy, hilo_we, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
    wc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (hilo_we || busy) wc++;
    end
    vectors++;
    if (wc !== 0) begin
      errors++;
      $display("FAIL async_reset_quiet: %0d cycles with busy/strobe, required 0", wc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_cancel();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
